// File: rtl/stream_demux_1_n.sv
// stream_demux_1_n: registered 1-to-N stream demultiplexer with valid/ready.
// A single holding register sits between the producer and N_CH consumer
// channels. Words whose select is >= N_CH are accepted and discarded, and
// each one is counted in a saturating drop counter.
//
// Optional build macro STREAM_DEMUX_ZERO_IDLE_EN:
//   defined   - an out_data slice shows hold_data only while its channel is
//               valid, and all zeros otherwise.
//   undefined - every out_data slice carries hold_data (shared bus).
//               Consumers must qualify the data with out_valid.
module stream_demux_1_n #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic                     drop_pulse,
  output logic [CNT_W-1:0]         drop_cnt
);

  // One extra bit so that N_CH == 2**SEL_W is still representable.
  localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

  logic                    hold_valid;
  logic [SEL_W-1:0]        hold_sel;
  logic [DATA_W-1:0]       hold_data;

  logic [2**SEL_W-1:0]     ready_ext;
  logic                    sel_ok;
  logic                    accept;
  logic                    drop;
  logic                    drain;

  // Zero-extend the ready vector so that it can be indexed by the full select range.
  always_comb begin
    ready_ext            = '0;
    ready_ext[N_CH-1:0]  = out_ready;
  end

  assign sel_ok   = ({1'b0, in_sel} < N_CH_L);
  assign drain    = hold_valid && ready_ext[hold_sel];
  assign in_ready = !hold_valid || ready_ext[hold_sel];
  assign accept   = in_valid && in_ready;
  assign drop     = accept && !sel_ok;

  // Holding register: reload on an in-range accept (even while draining), otherwise empty on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_sel   <= '0;
      hold_data  <= '0;
    end else if (accept && sel_ok) begin
      hold_valid <= 1'b1;
      hold_sel   <= in_sel;
      hold_data  <= in_data;
    end else if (drain) begin
      hold_valid <= 1'b0;
    end
  end

  // Drop accounting: one-cycle pulse per discarded word, and a counter that saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  // Per-channel valid decode from the holding register (at most one bit set).
  always_comb begin
    out_valid = '0;
    for (int k = 0; k < N_CH; k++) begin
      out_valid[k] = hold_valid && (hold_sel == SEL_W'(k));
    end
  end

  // Output data fan-out, either gated per channel or a shared bus.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < N_CH; k++) begin
`ifdef STREAM_DEMUX_ZERO_IDLE_EN
      out_data[k*DATA_W +: DATA_W] = out_valid[k] ? hold_data : '0;
`else
      out_data[k*DATA_W +: DATA_W] = hold_data;
`endif
    end
  end

endmodule
